// File: rtl/req_handshake_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : req_handshake_tx
//  Description : Four-phase req/ack transmitter. Accepts one payload word
//                from a valid/ready producer, latches it onto data_out and
//                raises req toward a CPU input PIO. The CPU answers through
//                an output PIO (ack), which is asynchronous to clk and is
//                brought in through a 2-flop synchronizer. A request that
//                is not acknowledged within TIMEOUT_CYC cycles is abandoned
//                with a one-cycle timeout pulse.
//
//  Ports       : clk       in   system clock, rising edge
//                reset_n   in   asynchronous, active-low reset
//                s_data    in   [DATA_W] payload from producer
//                s_valid   in   s_data is valid
//                s_ready   out  word is accepted this cycle
//                req       out  request line to CPU input PIO
//                data_out  out  [DATA_W] latched payload for CPU data PIO
//                ack       in   acknowledge from CPU output PIO (async)
//                busy      out  high whenever a handshake is in progress
//                timeout   out  one-cycle pulse when a request is abandoned
//
//  Revision    : 1.0  initial release
// ============================================================================
module req_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              req,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack,
    output logic              busy,
    output logic              timeout
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_WAIT_ACK_HI = 2'd1;
    localparam logic [1:0] c_WAIT_ACK_LO = 2'd2;

    // Last counter value before a request is given up.
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic              r_ack_meta;
    logic              r_ack_s;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req;
    logic [DATA_W-1:0] r_data;
    logic              r_timeout;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_req_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_timeout_nxt;
    logic              w_ready;
    logic              w_accept;
    logic              w_cnt_at_max;

    // ------------------------------------------------------------------
    // Acknowledge synchronizer. Raw ack is only ever sampled here; every
    // other piece of logic looks at r_ack_s.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    // ------------------------------------------------------------------
    // Producer side. Holding ready low while the synchronized ack is
    // still high guarantees a new req never rises before the CPU has
    // finished the previous four-phase cycle, including a spurious ack
    // seen while idle or an ack stuck high out of reset.
    // ------------------------------------------------------------------
    assign w_ready      = (r_state == c_IDLE) && !r_ack_s;
    assign w_accept     = s_valid && w_ready;
    assign w_cnt_at_max = (r_cnt == c_CNT_MAX);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_req_nxt     = r_req;
        w_data_nxt    = r_data;
        w_timeout_nxt = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_WAIT_ACK_HI;
                    w_req_nxt   = 1'b1;
                    w_data_nxt  = s_data;
                    w_cnt_nxt   = '0;
                end
            end

            c_WAIT_ACK_HI: begin
                // A real acknowledge wins over an expiring counter, so an
                // ack landing exactly on the last cycle is not a timeout.
                if (r_ack_s) begin
                    w_state_nxt = c_WAIT_ACK_LO;
                    w_req_nxt   = 1'b0;
                end else if (w_cnt_at_max) begin
                    w_state_nxt   = c_WAIT_ACK_LO;
                    w_req_nxt     = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    // Stops at c_CNT_MAX because the branch above leaves
                    // the state first; the counter can never wrap.
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_WAIT_ACK_LO: begin
                // After a timeout ack_s is normally already low, so this
                // state lasts a single cycle and the block drops to IDLE.
                w_req_nxt = 1'b0;
                if (!r_ack_s) begin
                    w_state_nxt = c_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_req     <= w_req_nxt;
            r_data    <= w_data_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_ready  = w_ready;
    assign req      = r_req;
    assign data_out = r_data;
    assign busy     = (r_state != c_IDLE);
    assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_req_handshake_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_req_handshake_tx
//  Description : Directed self-checking bench for req_handshake_tx with a
//                payload scoreboard (expected words queued on acceptance,
//                compared when req rises).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_req_handshake_tx;

    logic       clk;
    logic       reset_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       req;
    logic [7:0] data_out;
    logic       ack;
    logic       busy;
    logic       timeout;

    int         n_vec;
    int         n_miss;
    logic [7:0] sb_q[$];

    req_handshake_tx #(
        .DATA_W      (8),
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .req      (req),
        .data_out (data_out),
        .ack      (ack),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag);
        logic [7:0] exp;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $error("FAIL %s: observed %0h expected <none queued>", tag, data_out);
        end else begin
            exp = sb_q.pop_front();
            check(tag, data_out, exp);
        end
    endtask

    task automatic finish_handshake(input string tag);
        ack = 1'b1;
        repeat (3) tick();
        check({tag, "_req_fall"}, req, 0);
        ack = 1'b0;
        repeat (3) tick();
        check({tag, "_ready_back"}, s_ready, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        reset_n = 1'b0;
        ack     = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;

        // Reset state
        repeat (3) tick();
        check("rst_req", req, 0);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_ready", s_ready, 1);
        reset_n = 1'b1;
        tick();

        // Basic handshake with 0xA5
        s_data  = 8'hA5;
        s_valid = 1'b1;
        check("basic_ready", s_ready, 1);
        sb_q.push_back(8'hA5);
        tick();
        s_valid = 1'b0;
        s_data  = 8'h00;
        check("basic_req_rise", req, 1);
        check_sb("basic_data");
        check("basic_busy", busy, 1);
        check("basic_ready_low", s_ready, 0);
        repeat (3) begin
            tick();
            check("basic_req_hold", req, 1);
        end
        ack = 1'b1;
        repeat (2) begin
            tick();
            check("basic_req_pre_ack", req, 1);
        end
        tick();
        check("basic_req_fall", req, 0);
        check("basic_busy_lo", busy, 1);
        check("basic_no_timeout", timeout, 0);
        ack = 1'b0;
        repeat (2) begin
            tick();
            check("basic_ready_wait", s_ready, 0);
            check("basic_req_low", req, 0);
        end
        tick();
        check("basic_ready_back", s_ready, 1);
        check("basic_idle", busy, 0);
        check("basic_data_kept", data_out, 8'hA5);

        // Timeout with no ack: pulse 16 cycles after req rises
        s_data  = 8'h3C;
        s_valid = 1'b1;
        sb_q.push_back(8'h3C);
        tick();
        s_valid = 1'b0;
        check("to_req_rise", req, 1);
        check_sb("to_data");
        for (int i = 1; i < 16; i++) begin
            tick();
            check("to_quiet", timeout, 0);
            check("to_req_hold", req, 1);
        end
        tick();
        check("to_pulse", timeout, 1);
        check("to_req_fall", req, 0);
        tick();
        check("to_pulse_end", timeout, 0);
        check("to_idle", busy, 0);
        check("to_ready", s_ready, 1);

        // Boundary: ack_s arrives exactly as the counter reaches 15
        s_data  = 8'hC3;
        s_valid = 1'b1;
        sb_q.push_back(8'hC3);
        tick();
        s_valid = 1'b0;
        check("bnd_req_rise", req, 1);
        check_sb("bnd_data");
        repeat (13) tick();
        ack = 1'b1;
        repeat (2) tick();
        check("bnd_req_hold", req, 1);
        check("bnd_quiet", timeout, 0);
        tick();
        check("bnd_no_timeout", timeout, 0);
        check("bnd_req_fall", req, 0);
        check("bnd_busy", busy, 1);
        tick();
        check("bnd_no_late_pulse", timeout, 0);
        check("bnd_wait_lo", busy, 1);
        ack = 1'b0;
        repeat (3) tick();
        check("bnd_ready_back", s_ready, 1);

        // Back-to-back with s_valid held
        s_data  = 8'h01;
        s_valid = 1'b1;
        check("b2b_ready", s_ready, 1);
        sb_q.push_back(8'h01);
        tick();
        check("b2b_req1", req, 1);
        check_sb("b2b_data1");
        s_data = 8'h02;
        repeat (2) tick();
        check("b2b_hold_data", data_out, 8'h01);
        check("b2b_not_ready", s_ready, 0);
        ack = 1'b1;
        repeat (3) tick();
        check("b2b_req_fall", req, 0);
        check("b2b_data_ackhi", data_out, 8'h01);
        ack = 1'b0;
        repeat (2) begin
            tick();
            check("b2b_ready_wait", s_ready, 0);
            check("b2b_data_wait", data_out, 8'h01);
            check("b2b_req_low", req, 0);
        end
        tick();
        check("b2b_ready2", s_ready, 1);
        check("b2b_data_still1", data_out, 8'h01);
        sb_q.push_back(8'h02);
        tick();
        s_valid = 1'b0;
        check("b2b_req2", req, 1);
        check_sb("b2b_data2");
        finish_handshake("b2b");

        // Reset asserted mid-handshake
        s_data  = 8'h5A;
        s_valid = 1'b1;
        sb_q.push_back(8'h5A);
        tick();
        s_valid = 1'b0;
        check("mid_req_rise", req, 1);
        check_sb("mid_data");
        repeat (2) tick();
        reset_n = 1'b0;
        #2;
        check("mid_async_req", req, 0);
        check("mid_async_data", data_out, 0);
        check("mid_async_busy", busy, 0);
        check("mid_async_timeout", timeout, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (20) begin
            tick();
            check("mid_no_timeout", timeout, 0);
        end
        check("mid_idle", busy, 0);

        // Ack stuck high across reset release
        reset_n = 1'b0;
        ack     = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        s_data  = 8'h77;
        s_valid = 1'b1;
        repeat (4) begin
            check("stuck_ready", s_ready, 0);
            check("stuck_no_req", req, 0);
            tick();
        end
        ack = 1'b0;
        tick();
        check("stuck_ready_k", s_ready, 0);
        check("stuck_req_k", req, 0);
        tick();
        check("stuck_ready_k1", s_ready, 1);
        check("stuck_req_k1", req, 0);
        sb_q.push_back(8'h77);
        tick();
        s_valid = 1'b0;
        check("stuck_req_rise", req, 1);
        check_sb("stuck_data");
        finish_handshake("stuck");

        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/req_handshake_tx.md
REQ_HANDSHAKE_TX -- requirements
Module: req_handshake_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1000000, giving the maximum number of cycles req waits for ack.
REQ-003 The block SHALL have parameter CNT_W, default 20, giving the timeout counter width; it SHALL hold TIMEOUT_CYC-1.
REQ-004 clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 s_data  input  DATA_W  payload from the upstream producer.
REQ-007 s_valid  input  1  s_data is valid.
REQ-008 s_ready  output  1  the block accepts s_data this cycle.
REQ-009 req  output  1  request line driving the single-bit request input PIO read by the CPU.
REQ-010 data_out  output  DATA_W  latched payload, read by the CPU through a data PIO.
REQ-011 ack  input  1  acknowledge from the CPU output PIO; treated as asynchronous.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 timeout  output  1  single-cycle pulse when a request is abandoned.

Function
REQ-014 The block SHALL pass ack through a 2-flop synchronizer (ack_s); no logic other than the synchronizer SHALL use raw ack.
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT_ACK_HI and WAIT_ACK_LO.
REQ-016 s_ready SHALL be 1 only when state is IDLE and ack_s is 0, and SHALL be combinational from those two signals.
REQ-017 Transfer: in IDLE, s_valid=1 and s_ready=1 at edge N SHALL latch s_data into data_out, set req=1 and enter WAIT_ACK_HI, all visible after edge N.
REQ-018 data_out SHALL stay stable from a transfer until the next accepted transfer.
REQ-019 WAIT_ACK_HI with ack_s=1 SHALL clear req and enter WAIT_ACK_LO on the next edge; ack rising before edge K SHALL make req 0 after edge K+2.
REQ-020 WAIT_ACK_LO with ack_s=0 SHALL enter IDLE on the next edge; req SHALL stay 0 throughout WAIT_ACK_LO.
REQ-021 A 4-phase cycle SHALL complete: req up, ack up, req down, ack down; a new req SHALL never rise while ack_s=1.
REQ-022 The timeout counter SHALL clear on entry to WAIT_ACK_HI and increment once per cycle while in WAIT_ACK_HI.
REQ-023 When the counter equals TIMEOUT_CYC-1 and ack_s=0, the block SHALL pulse timeout for exactly one cycle, clear req and enter WAIT_ACK_LO.
REQ-024 If ack_s=1 in the cycle the counter reaches TIMEOUT_CYC-1, the block SHALL treat it as a normal acknowledge, with no timeout pulse.
REQ-025 The counter SHALL never wrap, and SHALL hold its value outside WAIT_ACK_HI.
REQ-026 s_valid in any non-IDLE state SHALL be ignored; nothing SHALL be queued.
REQ-027 Spurious ack in IDLE SHALL only hold s_ready low until ack_s returns to 0.

Reset
REQ-028 reset_n=0 SHALL force, asynchronously: state IDLE, req=0, data_out=0, timeout=0, counter=0, synchronizer flops=0.
REQ-029 Reset asserted mid-handshake SHALL abandon the transfer with no timeout pulse.
REQ-030 After reset release, the first transfer SHALL be accepted only once ack_s=0.

Verification
REQ-031 Basic handshake: s_data=0xA5 with s_valid for 1 cycle -> req=1 and data_out=0xA5 next cycle; ack=1 -> req=0 after 3 edges; ack=0 -> s_ready=1 after 3 edges.
REQ-032 Timeout (TIMEOUT_CYC=16), no ack: timeout pulses once exactly 16 cycles after req rises, and req falls in the same cycle; block returns to IDLE with ack=0.
REQ-033 Boundary: ack_s reaches 1 in the same cycle the counter hits 15 -> no timeout pulse, normal WAIT_ACK_LO.
REQ-034 Back-to-back: s_valid held with 0x01 then 0x02 -> second word accepted only after ack falls; data_out=0x01 unchanged until then.
REQ-035 Reset mid-op: reset_n pulsed low in WAIT_ACK_HI -> req=0 and data_out=0x00 immediately, with no clock edge needed.
REQ-036 Ack stuck high at reset release: s_ready=0 until 2 edges after ack falls, and no req is issued meanwhile.
